spm_dpram2: RTL

Parametrised true dual-port scratchpad RAM for the SPM (scratchpad memory) path. It generalises the fixed-width dual-port SPM with:
- per-byte write enables
- a selectable same-cycle collision read mode
- an optional output pipeline stage
- a hardware clear engine that zeroes the whole array after reset or on request

Both ports share one clock. It sits between the CPU core's memory stage (port A) and the DMA/bus side (port B).

---
 rtl/spm_dpram2.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spm_dpram2.sv
// True dual-port scratchpad RAM with byte enables, collision read mode and a zeroing clear engine.
// Latency: read data/valid 1 cycle after the enable cycle (2 with OUT_REG=1), one access per port per cycle.
// Backpressure: none; accesses presented while init_busy is high are dropped (no write, no rvalid).
//
// Ports:
//   clk, reset            shared clock, asynchronous active-high reset
//   clear_req / init_busy start a full-array clear when idle / high while the clear engine runs
//   a_* / b_*             en, we, be, addr, wdata in; rdata, rvalid out (identical ports)
module spm_dpram2 #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                init_busy,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                ready;
    logic                same_addr;
    logic [NB-1:0]       a_wr_be, b_wr_be;
    logic [DATA_W-1:0]   a_old, b_old, a_new, b_new, a_word, b_word;

    // Overlay the enabled bytes of wdata onto base.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] base,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- clear engine FSM ----------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d    = ST_READY;
                    clr_addr_d = '0;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_READY;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign ready     = (state_q == ST_READY);
    assign init_busy = (state_q == ST_CLEAR);

    // ---------------- access / collision resolution ----------------
    // Effective write masks are zero unless the port is really writing this cycle.
    assign a_wr_be   = (ready && a_en && a_we) ? a_be : '0;
    assign b_wr_be   = (ready && b_en && b_we) ? b_be : '0;
    assign same_addr = (a_addr == b_addr);

    assign a_old = mem_q[a_addr];
    assign b_old = mem_q[b_addr];

    // Both resolved words apply B first then A, so A wins on shared bytes and the
    // two words are identical when the addresses match.
    assign a_new = merge_bytes(merge_bytes(a_old, b_wdata, same_addr ? b_wr_be : '0),
                               a_wdata, a_wr_be);
    assign b_new = merge_bytes(merge_bytes(b_old, b_wdata, b_wr_be),
                               a_wdata, same_addr ? a_wr_be : '0);

    assign a_word = (RD_MODE != 0) ? a_old : a_new;
    assign b_word = (RD_MODE != 0) ? b_old : b_new;

    always_ff @(posedge clk) begin
        if (!ready) begin
            mem_q[clr_addr_q] <= '0;
        end else begin
            if (|a_wr_be) mem_q[a_addr] <= a_new;
            if (|b_wr_be) mem_q[b_addr] <= b_new;
        end
    end

    // ---------------- read pipeline ----------------
    logic [DATA_W-1:0] a_rdata1_q, b_rdata1_q;
    logic              a_rvalid1_q, b_rvalid1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata1_q  <= '0;
            b_rdata1_q  <= '0;
            a_rvalid1_q <= 1'b0;
            b_rvalid1_q <= 1'b0;
        end else begin
            a_rvalid1_q <= ready && a_en;
            b_rvalid1_q <= ready && b_en;
            if (ready && a_en) a_rdata1_q <= a_word;
            if (ready && b_en) b_rdata1_q <= b_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] a_rdata2_q, b_rdata2_q;
            logic              a_rvalid2_q, b_rvalid2_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_rdata2_q  <= '0;
                    b_rdata2_q  <= '0;
                    a_rvalid2_q <= 1'b0;
                    b_rvalid2_q <= 1'b0;
                end else begin
                    a_rvalid2_q <= a_rvalid1_q;
                    b_rvalid2_q <= b_rvalid1_q;
                    if (a_rvalid1_q) a_rdata2_q <= a_rdata1_q;
                    if (b_rvalid1_q) b_rdata2_q <= b_rdata1_q;
                end
            end

            assign a_rdata  = a_rdata2_q;
            assign b_rdata  = b_rdata2_q;
            assign a_rvalid = a_rvalid2_q;
            assign b_rvalid = b_rvalid2_q;
        end else begin : g_no_out_reg
            assign a_rdata  = a_rdata1_q;
            assign b_rdata  = b_rdata1_q;
            assign a_rvalid = a_rvalid1_q;
            assign b_rvalid = b_rvalid1_q;
        end
    endgenerate

endmodule
